// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the five-stage pipeline.
// Holds the opcode and funct encodings, the ALU control (id_aluc) and PC-select (pcsrc)
// encodings, the operand forward-select encoding, and the forwarding priority function.
package cpu_pkg;

    localparam int unsigned NREG = 32;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (inst[5:0])
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluXor = 3'b100,
        AluSll = 3'b101,
        AluSrl = 3'b110,
        AluSra = 3'b111
    } aluc_e;

    typedef enum logic [1:0] {
        PcSeq    = 2'b00,
        PcBranch = 2'b01,
        PcJump   = 2'b10
    } pcsrc_e;

    typedef enum logic [1:0] {
        FwdRf     = 2'b00,
        FwdExeAlu = 2'b01,
        FwdMemAlu = 2'b10,
        FwdMemMo  = 2'b11
    } fwd_e;

    // Operand source for one register read. EXE has priority over MEM; a load still in
    // EXE cannot forward (its data does not exist yet) and is handled as a stall.
    function automatic fwd_e fwd_select(input logic [4:0] src,
                                        input logic [4:0] exe_rn,
                                        input logic       exe_wreg,
                                        input logic       exe_m2reg,
                                        input logic [4:0] mem_rn,
                                        input logic       mem_wreg,
                                        input logic       mem_m2reg);
        fwd_e sel;
        sel = FwdRf;
        if (src != 5'd0) begin
            if (exe_wreg && !exe_m2reg && (exe_rn == src)) begin
                sel = FwdExeAlu;
            end else if (mem_wreg && (mem_rn == src)) begin
                sel = mem_m2reg ? FwdMemMo : FwdMemAlu;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile.sv
// regfile: NREG x 32 register file for the decode stage.
// Ports: clk, clrn (async active-low clear); rna/rnb read addresses with asynchronous
// data qa/qb; we/wn/d single write port committed on posedge clk.
// Register 0 always reads zero. A read of the register being written this cycle returns
// the write data (WB bypass). While clrn is low every register, bypass included, reads 0.
module regfile
    import cpu_pkg::*;
#(
    parameter int unsigned NREG = cpu_pkg::NREG
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [4:0]  rna,
    input  logic [4:0]  rnb,
    input  logic        we,
    input  logic [4:0]  wn,
    input  logic [31:0] d,
    output logic [31:0] qa,
    output logic [31:0] qb
);

    logic [31:0] regs [NREG];
    logic        byp_en;

    // Reset has priority, so a write landing on the same edge as reset is discarded.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wn != 5'd0)) begin
            regs[wn] <= d;
        end
    end

    assign byp_en = clrn && we && (wn != 5'd0);

    always_comb begin
        qa = regs[rna];
        if (rna == 5'd0) begin
            qa = '0;
        end else if (byp_en && (wn == rna)) begin
            qa = d;
        end
    end

    always_comb begin
        qb = regs[rnb];
        if (rnb == 5'd0) begin
            qb = '0;
        end else if (byp_en && (wn == rnb)) begin
            qb = d;
        end
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction decode stage of the five-stage pipeline.
// Inputs: clk, clrn (async active-low), inst/dpc4 from IF/ID, destination registers and
// pending-write flags of EXE/MEM/WB, and their forwardable values.
// Outputs: wpcir (0 = stall PC and IF/ID), pcsrc/bpc/jpc for next-PC selection, and all
// id_* controls and operands for the ID/EXE register.
// Build option: define ID_FORWARD_EN to forward EXE/MEM results into id_ra/id_rb; without
// it the register file (with WB bypass) is the only source and any EXE/MEM hit stalls.
module id_stage
    import cpu_pkg::*;
#(
    parameter int unsigned NREG = cpu_pkg::NREG
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] inst,
    input  logic [31:0] dpc4,
    input  logic [4:0]  exe_rn,
    input  logic [4:0]  mem_rn,
    input  logic [4:0]  wb_rn,
    input  logic        exe_wreg,
    input  logic        exe_m2reg,
    input  logic        mem_wreg,
    input  logic        mem_m2reg,
    input  logic        wb_wreg,
    input  logic [31:0] exe_alu,
    input  logic [31:0] mem_alu,
    input  logic [31:0] mem_mo,
    input  logic [31:0] wb_data,
    output logic        wpcir,
    output logic [1:0]  pcsrc,
    output logic [31:0] bpc,
    output logic [31:0] jpc,
    output logic        id_m2reg,
    output logic        id_wmem,
    output logic        id_aluimm,
    output logic        id_shift,
    output logic        id_wreg,
    output logic [2:0]  id_aluc,
    output logic [4:0]  id_rn,
    output logic [31:0] id_ra,
    output logic [31:0] id_rb,
    output logic [31:0] id_imm
);

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm16;
    logic [31:0] sext, zext;

    assign op    = inst[31:26];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign sa    = inst[10:6];
    assign fn    = inst[5:0];
    assign imm16 = inst[15:0];
    assign sext  = {{16{imm16[15]}}, imm16};
    assign zext  = {16'd0, imm16};

    // ---------------------------------------------------------------- decode
    logic  dec_wreg, dec_wmem, dec_m2reg, dec_aluimm, dec_shift;
    logic  use_rs, use_rt, is_beq, is_bne, is_j;
    aluc_e dec_aluc;

    always_comb begin
        dec_wreg   = 1'b0;
        dec_wmem   = 1'b0;
        dec_m2reg  = 1'b0;
        dec_aluimm = 1'b0;
        dec_shift  = 1'b0;
        use_rs     = 1'b0;
        use_rt     = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        dec_aluc   = AluAdd;
        id_rn      = 5'd0;
        id_imm     = sext;
        case (op)
            OP_RTYPE: begin
                id_rn = rd;
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR: begin
                        dec_wreg = 1'b1;
                        use_rs   = 1'b1;
                        use_rt   = 1'b1;
                        case (fn)
                            FN_SUB:  dec_aluc = AluSub;
                            FN_AND:  dec_aluc = AluAnd;
                            FN_OR:   dec_aluc = AluOr;
                            FN_XOR:  dec_aluc = AluXor;
                            default: dec_aluc = AluAdd;
                        endcase
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        // Shift amount travels in id_imm; rs is not a source.
                        dec_wreg  = 1'b1;
                        dec_shift = 1'b1;
                        use_rt    = 1'b1;
                        id_imm    = {27'd0, sa};
                        case (fn)
                            FN_SRL:  dec_aluc = AluSrl;
                            FN_SRA:  dec_aluc = AluSra;
                            default: dec_aluc = AluSll;
                        endcase
                    end
                    default: id_rn = 5'd0;
                endcase
            end
            OP_ADDI: begin
                dec_wreg   = 1'b1;
                dec_aluimm = 1'b1;
                use_rs     = 1'b1;
                id_rn      = rt;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec_wreg   = 1'b1;
                dec_aluimm = 1'b1;
                use_rs     = 1'b1;
                id_rn      = rt;
                id_imm     = zext;
                case (op)
                    OP_ANDI: dec_aluc = AluAnd;
                    OP_ORI:  dec_aluc = AluOr;
                    default: dec_aluc = AluXor;
                endcase
            end
            OP_LW: begin
                dec_wreg   = 1'b1;
                dec_m2reg  = 1'b1;
                dec_aluimm = 1'b1;
                use_rs     = 1'b1;
                id_rn      = rt;
            end
            OP_SW: begin
                dec_wmem   = 1'b1;
                dec_aluimm = 1'b1;
                use_rs     = 1'b1;
                use_rt     = 1'b1;
                id_rn      = rt;
            end
            OP_BEQ, OP_BNE: begin
                is_beq   = (op == OP_BEQ);
                is_bne   = (op == OP_BNE);
                use_rs   = 1'b1;
                use_rt   = 1'b1;
                id_rn    = rt;
                dec_aluc = AluSub;
            end
            OP_J: is_j = 1'b1;
            default: id_rn = 5'd0;
        endcase
    end

    // ---------------------------------------------------------------- operands
    logic [31:0] qa, qb;

    regfile #(
        .NREG(NREG)
    ) u_regfile (
        .clk  (clk),
        .clrn (clrn),
        .rna  (rs),
        .rnb  (rt),
        .we   (wb_wreg),
        .wn   (wb_rn),
        .d    (wb_data),
        .qa   (qa),
        .qb   (qb)
    );

    logic hit_a, hit_b, stall;

`ifdef ID_FORWARD_EN
    fwd_e sel_a, sel_b;

    assign sel_a = fwd_select(rs, exe_rn, exe_wreg, exe_m2reg, mem_rn, mem_wreg, mem_m2reg);
    assign sel_b = fwd_select(rt, exe_rn, exe_wreg, exe_m2reg, mem_rn, mem_wreg, mem_m2reg);

    always_comb begin
        unique case (sel_a)
            FwdExeAlu: id_ra = exe_alu;
            FwdMemAlu: id_ra = mem_alu;
            FwdMemMo:  id_ra = mem_mo;
            default:   id_ra = qa;
        endcase
        unique case (sel_b)
            FwdExeAlu: id_rb = exe_alu;
            FwdMemAlu: id_rb = mem_alu;
            FwdMemMo:  id_rb = mem_mo;
            default:   id_rb = qb;
        endcase
    end

    // An EXE result can be forwarded to the ALU but not in time for the ID-stage branch
    // compare, so branches wait as well as load consumers.
    assign hit_a = use_rs && (rs != 5'd0) && exe_wreg && (exe_rn == rs) &&
                   (exe_m2reg || is_beq || is_bne);
    assign hit_b = use_rt && (rt != 5'd0) && exe_wreg && (exe_rn == rt) &&
                   (exe_m2reg || is_beq || is_bne);
`else
    logic unused_fwd;

    assign unused_fwd = ^{exe_alu, mem_alu, mem_mo, exe_m2reg, mem_m2reg};
    assign id_ra      = qa;
    assign id_rb      = qb;

    // Without forwarding, any in-flight write to a source must drain through WB first.
    assign hit_a = use_rs && (rs != 5'd0) &&
                   ((exe_wreg && (exe_rn == rs)) || (mem_wreg && (mem_rn == rs)));
    assign hit_b = use_rt && (rt != 5'd0) &&
                   ((exe_wreg && (exe_rn == rt)) || (mem_wreg && (mem_rn == rt)));
`endif

    assign stall = hit_a || hit_b;

    // ---------------------------------------------------------------- branch / outputs
    logic   taken;
    pcsrc_e pcsrc_raw;

    assign taken     = (is_beq && (id_ra == id_rb)) || (is_bne && (id_ra != id_rb));
    assign pcsrc_raw = is_j ? PcJump : (taken ? PcBranch : PcSeq);

    assign bpc = dpc4 + {sext[29:0], 2'b00};
    assign jpc = {dpc4[31:28], inst[25:0], 2'b00};

    // A stall turns this slot into a bubble: nothing is written and the PC holds.
    assign wpcir     = !stall;
    assign pcsrc     = stall ? PcSeq : pcsrc_raw;
    assign id_wreg   = dec_wreg && !stall;
    assign id_wmem   = dec_wmem && !stall;
    assign id_m2reg  = dec_m2reg;
    assign id_aluimm = dec_aluimm;
    assign id_shift  = dec_shift;
    assign id_aluc   = dec_aluc;

endmodule
